// File: rtl/gfx_dev_slave_if.sv
// Switch-to-device bus: command beats flow into the device, response beats flow back.
interface gfx_dev_slave_if;
  logic        selin;
  logic [2:0]  cmdin;
  logic [31:0] addrdatain;
  logic [1:0]  lenin;
  logic        ackin;
  logic        reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [31:0] addrdataout;
  logic [1:0]  lenout;

  modport slave (
    input  selin, cmdin, addrdatain, lenin, ackin,
    output reqout, reqtar, cmdout, addrdataout, lenout
  );

  modport master (
    output selin, cmdin, addrdatain, lenin, ackin,
    input  reqout, reqtar, cmdout, addrdataout, lenout
  );
endinterface

// File: rtl/gfx_dev_slave.sv
// Graphics device target port: 16-word register file reached by read/write bursts,
// answered with READ_DATA / WRITE_ACK / ERROR beats; register 0 drives ctrl_out.
module gfx_dev_slave #(
  parameter logic [31:0] BASE = 32'hF000_0000,
  parameter int unsigned NREG = 16
) (
  input  logic                clk,
  input  logic                reset,
  gfx_dev_slave_if.slave      bus,
  output logic [31:0]         ctrl_out,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StWdata, StResp} state_e;

  localparam logic [2:0] CmdIdle     = 3'd0;
  localparam logic [2:0] CmdRead     = 3'd1;
  localparam logic [2:0] CmdWrite    = 3'd2;
  localparam logic [2:0] CmdReadData = 3'd3;
  localparam logic [2:0] CmdWriteAck = 3'd4;
  localparam logic [2:0] CmdError    = 3'd5;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  len_q, len_d;
  logic [1:0]  beat_q, beat_d;
  logic        reqout_q, reqout_d;
  logic [2:0]  cmdout_q, cmdout_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  lenout_q, lenout_d;
  logic [31:0] regs_q [NREG];

  logic        we;
  logic [3:0]  wr_idx;
  logic [3:0]  next_idx;

  // Register index wraps modulo 16 across a burst.
  assign wr_idx   = addr_q[5:2] + {2'b00, beat_q};
  assign next_idx = wr_idx + 4'd1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    reqout_d = reqout_q;
    cmdout_d = cmdout_q;
    data_d   = data_q;
    lenout_d = lenout_q;
    we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.selin && (bus.cmdin == CmdRead || bus.cmdin == CmdWrite)) begin
          addr_d = bus.addrdatain;
          len_d  = bus.lenin;
          beat_d = 2'd0;
          if (bus.addrdatain[31:8] != BASE[31:8]) begin
            state_d  = StResp;
            reqout_d = 1'b1;
            cmdout_d = CmdError;
            lenout_d = 2'd0;
            data_d   = bus.addrdatain;
          end else if (bus.cmdin == CmdWrite) begin
            state_d = StWdata;
          end else begin
            state_d  = StResp;
            reqout_d = 1'b1;
            cmdout_d = CmdReadData;
            lenout_d = bus.lenin;
            data_d   = regs_q[bus.addrdatain[5:2]];
          end
        end
      end
      StWdata: begin
        if (bus.selin) begin
          we = 1'b1;
          if (beat_q == len_q) begin
            state_d  = StResp;
            reqout_d = 1'b1;
            cmdout_d = CmdWriteAck;
            lenout_d = 2'd0;
            data_d   = addr_q;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else begin
          // Switch dropped select mid-burst: committed beats stay, no ack.
          state_d = StIdle;
        end
      end
      StResp: begin
        if (reqout_q && bus.ackin) begin
          if (cmdout_q != CmdReadData || beat_q == len_q) begin
            state_d  = StIdle;
            reqout_d = 1'b0;
            cmdout_d = CmdIdle;
            lenout_d = 2'd0;
            data_d   = '0;
          end else begin
            beat_d = beat_q + 2'd1;
            data_d = regs_q[next_idx];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      reqout_q <= 1'b0;
      cmdout_q <= CmdIdle;
      data_q   <= '0;
      lenout_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      reqout_q <= reqout_d;
      cmdout_q <= cmdout_d;
      data_q   <= data_d;
      lenout_q <= lenout_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[wr_idx] <= bus.addrdatain;
    end
  end

  assign bus.reqout      = reqout_q;
  assign bus.reqtar      = reqout_q ? 4'hF : 4'h0;
  assign bus.cmdout      = cmdout_q;
  assign bus.addrdataout = data_q;
  assign bus.lenout      = lenout_q;
  assign ctrl_out        = regs_q[0];
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_gfx_dev_slave.sv
// Directed bench for gfx_dev_slave: bursts, wrap, window error, stalls, abort, reset.
module tb_gfx_dev_slave;

  logic        clk;
  logic        reset;
  logic [31:0] ctrl_out;
  logic        busy;
  int          n_checks;
  int          n_fails;

  gfx_dev_slave_if bus ();

  gfx_dev_slave #(
    .BASE (32'hF000_0000),
    .NREG (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .ctrl_out (ctrl_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.selin      = 1'b0;
    bus.cmdin      = 3'd0;
    bus.addrdatain = '0;
    bus.lenin      = 2'd0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] len,
                          input logic [127:0] data);
    bus.selin = 1'b1; bus.cmdin = 3'd2; bus.addrdatain = addr; bus.lenin = len;
    tick();
    bus.cmdin = 3'd0;
    for (int b = 0; b <= int'(len); b++) begin
      bus.addrdatain = data[b*32 +: 32];
      tick();
    end
    idle_bus();
    check_eq("wr_reqout", {31'd0, bus.reqout}, 32'd1);
    check_eq("wr_cmdout", {29'd0, bus.cmdout}, 32'd4);
    check_eq("wr_reqtar", {28'd0, bus.reqtar}, 32'hF);
    check_eq("wr_payload", bus.addrdataout, addr);
    check_eq("wr_lenout", {30'd0, bus.lenout}, 32'd0);
    bus.ackin = 1'b1;
    tick();
    bus.ackin = 1'b0;
    check_eq("wr_done_reqout", {31'd0, bus.reqout}, 32'd0);
    check_eq("wr_done_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] len,
                         input logic [127:0] exp, input int stall);
    bus.selin = 1'b1; bus.cmdin = 3'd1; bus.addrdatain = addr; bus.lenin = len;
    tick();
    idle_bus();
    check_eq("rd_lenout", {30'd0, bus.lenout}, {30'd0, len});
    for (int b = 0; b <= int'(len); b++) begin
      for (int s = 0; s < stall; s++) begin
        check_eq("rd_stall_reqout", {31'd0, bus.reqout}, 32'd1);
        check_eq("rd_stall_payload", bus.addrdataout, exp[b*32 +: 32]);
        tick();
      end
      check_eq("rd_reqout", {31'd0, bus.reqout}, 32'd1);
      check_eq("rd_cmdout", {29'd0, bus.cmdout}, 32'd3);
      check_eq("rd_reqtar", {28'd0, bus.reqtar}, 32'hF);
      check_eq("rd_payload", bus.addrdataout, exp[b*32 +: 32]);
      bus.ackin = 1'b1;
      tick();
      bus.ackin = 1'b0;
    end
    check_eq("rd_done_reqout", {31'd0, bus.reqout}, 32'd0);
    check_eq("rd_done_cmdout", {29'd0, bus.cmdout}, 32'd0);
    check_eq("rd_done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    bus.ackin = 1'b0;
    idle_bus();
    reset = 1'b0;
    repeat (2) tick();
    check_eq("rst_reqout", {31'd0, bus.reqout}, 32'd0);
    check_eq("rst_reqtar", {28'd0, bus.reqtar}, 32'd0);
    check_eq("rst_ctrl", ctrl_out, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    tick();

    // Reset mid-RESP of a 4-beat read.
    do_write(32'hF000_0000, 2'd0, {96'd0, 32'h0000_1234});
    check_eq("ctrl_pre_reset", ctrl_out, 32'h0000_1234);
    bus.selin = 1'b1; bus.cmdin = 3'd1; bus.addrdatain = 32'hF000_0000; bus.lenin = 2'd3;
    tick();
    idle_bus();
    check_eq("mid_reqout", {31'd0, bus.reqout}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_reqout", {31'd0, bus.reqout}, 32'd0);
    check_eq("async_busy", {31'd0, busy}, 32'd0);
    check_eq("async_ctrl", ctrl_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    do_read(32'hF000_0000, 2'd0, {96'd0, 32'd0}, 0);

    // Single write then read.
    do_write(32'hF000_0004, 2'd0, {96'd0, 32'hDEAD_BEEF});
    do_read(32'hF000_0004, 2'd0, {96'd0, 32'hDEAD_BEEF}, 0);

    // Wrapping burst: regs 14, 15, 0, 1.
    do_write(32'hF000_0038, 2'd3, {32'd4, 32'd3, 32'd2, 32'd1});
    do_read(32'hF000_0000, 2'd1, {64'd0, 32'd4, 32'd3}, 0);
    do_read(32'hF000_0038, 2'd1, {64'd0, 32'd2, 32'd1}, 0);
    check_eq("ctrl_after_wrap", ctrl_out, 32'd3);

    // Out-of-window read.
    bus.selin = 1'b1; bus.cmdin = 3'd1; bus.addrdatain = 32'hF000_0100; bus.lenin = 2'd2;
    tick();
    idle_bus();
    check_eq("err_reqout", {31'd0, bus.reqout}, 32'd1);
    check_eq("err_cmdout", {29'd0, bus.cmdout}, 32'd5);
    check_eq("err_lenout", {30'd0, bus.lenout}, 32'd0);
    check_eq("err_payload", bus.addrdataout, 32'hF000_0100);
    check_eq("err_reqtar", {28'd0, bus.reqtar}, 32'hF);
    bus.ackin = 1'b1;
    tick();
    bus.ackin = 1'b0;
    check_eq("err_done_reqout", {31'd0, bus.reqout}, 32'd0);
    do_read(32'hF000_0000, 2'd0, {96'd0, 32'd3}, 0);

    // 4-beat read with 3-cycle stalls before each ack.
    do_read(32'hF000_0038, 2'd3, {32'd4, 32'd3, 32'd2, 32'd1}, 3);

    // Write abort after one data beat.
    bus.selin = 1'b1; bus.cmdin = 3'd2; bus.addrdatain = 32'hF000_0000; bus.lenin = 2'd2;
    tick();
    bus.cmdin = 3'd0; bus.addrdatain = 32'h0000_00FF;
    tick();
    check_eq("abort_busy_mid", {31'd0, busy}, 32'd1);
    idle_bus();
    tick();
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_ctrl", ctrl_out, 32'h0000_00FF);
    for (int i = 0; i < 3; i++) begin
      check_eq("abort_no_ack", {31'd0, bus.reqout}, 32'd0);
      tick();
    end
    do_read(32'hF000_0004, 2'd0, {96'd0, 32'd4}, 0);

    // Non-command select in idle is ignored.
    bus.selin = 1'b1; bus.cmdin = 3'd6; bus.addrdatain = 32'hF000_0000;
    tick();
    idle_bus();
    check_eq("bad_cmd_busy", {31'd0, busy}, 32'd0);
    check_eq("bad_cmd_reqout", {31'd0, bus.reqout}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gfx_dev_slave.md
Name: gfx_dev_slave

Overview:
- Bus-side target port for one graphics device (D0-D3); sits directly downstream of the bus switch.
- Accepts read and write bursts routed to it by the switch and holds a 16-word register file.
- Returns read data or a write acknowledge to the switch using the request/ack handshake. All responses target reqtar 4'hF.
- Register 0 drives the device control output.

Parameters:
- BASE, 32'hF000_0000, device window base; window is BASE..BASE+8'hFF, selected by addr[31:8] == BASE[31:8].
- NREG, 16, register count (word-addressed by addr[5:2]; addr[7:6] ignored).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- selin  in  1  switch selects this device; high for every command-phase beat.
- cmdin  in  3  command: 0 IDLE, 1 READ, 2 WRITE.
- addrdatain  in  32  beat 0 = address; following beats = write data.
- lenin  in  2  burst length minus 1 (1..4 beats); sampled on beat 0.
- ackin  in  1  switch accepts the current response beat.
- reqout  out  1  response beat valid.
- reqtar  out  4  response target; constant 4'hF while reqout = 1, otherwise 0.
- cmdout  out  3  response command: 3 READ_DATA, 4 WRITE_ACK, 5 ERROR; 0 when idle.
- addrdataout  out  32  response payload.
- lenout  out  2  response length minus 1.
- ctrl_out  out  32  copy of register 0.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset = 0, async):
  - State goes to IDLE; all outputs and registers go to 0.
  - An in-flight burst is discarded with no response.
- States: IDLE, WDATA, RESP.
- IDLE:
  - A cycle with selin = 1 and cmdin in {1, 2} captures address, command and lenin; beat counter is cleared.
  - Address outside the window: go to RESP with ERROR, lenout = 0, payload = captured address.
  - WRITE in window: go to WDATA.
  - READ in window: go to RESP with READ_DATA, lenout = captured len.
  - selin = 1 with cmdin 0 or any other value is ignored.
- WDATA:
  - Each cycle with selin = 1 writes addrdatain to reg[idx], then increments idx and the beat counter.
  - After beat len+1, go to RESP with WRITE_ACK, lenout = 0, payload = start address.
  - selin = 0 in WDATA aborts: return to IDLE with no ack. Beats already written stay committed.
- Index arithmetic: idx = addr[5:2] + beat, modulo 16 (4-bit wrap). A burst starting at reg 14 with len 3 touches 14, 15, 0, 1.
- RESP:
  - reqout = 1 and the payload are registered and stable until the ackin cycle.
  - READ_DATA payload is reg[idx] for the current beat.
  - On the cycle ackin = 1 with reqout = 1:
    - If this was the last beat: next cycle reqout = 0 and the state goes to IDLE.
    - Otherwise: next cycle the payload becomes the next beat, with no bubble.
  - ackin while reqout = 0 is ignored.
  - selin asserted during RESP is ignored; the switch never overlaps commands.
- Write data is visible to a read that starts one cycle later.
- ctrl_out is updated the cycle after reg 0 is written.
- Response latency: first read beat has reqout = 1 on the cycle after the address beat.
- Bursts are sized by lenin, so no full or empty conditions exist.

Test Plan:
- Reset mid-RESP:
  - Stimulus: a 4-beat read is in progress; reset pulses low for 1 cycle.
  - Required: reqout = 0, busy = 0, ctrl_out = 0 asynchronously. A read of reg 0 afterwards returns 0.
- Single write then read, BASE = F000_0000:
  - Stimulus: WRITE addr F000_0004, len 0, data DEAD_BEEF.
  - Required: WRITE_ACK, reqtar F, payload F000_0004.
  - Then READ same address: READ_DATA DEAD_BEEF with reqout high the cycle after the address beat.
- Wrapping burst:
  - Stimulus: WRITE addr F000_0038 (idx 14), len 3, data 1, 2, 3, 4.
  - Then READ addr F000_0000, len 1: returns 3, 4.
  - Then READ addr F000_0038, len 1: returns 1, 2.
- Out-of-window access:
  - Stimulus: READ addr F000_0100 on a device with BASE = F000_0000.
  - Required: ERROR (5), lenout 0, payload F000_0100. Registers unchanged.
- Ack stalls:
  - Stimulus: 4-beat read with ackin held low for 3 cycles before each beat.
  - Required: reqout and payload stay constant through each stall; the 4 beats arrive in order with no duplicates.
- Write abort and control output:
  - Stimulus: WRITE F000_0000, len 2, selin dropped after 1 data beat of 0000_00FF.
  - Required: no WRITE_ACK, busy falls, ctrl_out = 0000_00FF, reg 1 unchanged.
